// File: rtl/div_seq_ctrl.sv
// Sequencer between EX and the multi-cycle divider: handles DIV/DIVU/REM/REMU,
// resolves divide-by-zero and signed overflow locally, and caches the last divider result.
module div_seq_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_valid,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [4:0]            i_rd,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rd,
    output logic                  o_div_start,
    output logic                  o_div_unsigned,
    output logic [DATA_WIDTH-1:0] o_div_a,
    output logic [DATA_WIDTH-1:0] o_div_b,
    input  logic [DATA_WIDTH-1:0] i_div_quotient,
    input  logic [DATA_WIDTH-1:0] i_div_remainder,
    input  logic                  i_div_done,
    output logic [2:0]            o_state
);

    // Handshake: a request (i_valid & funct3[2]) is held stable by EX while o_stall=1;
    // the result is taken in the single cycle o_valid=1, when o_stall is low.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
    logic                  uns_q, rem_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] quo_q, rmd_q;

    logic                  cache_valid_q;
    logic [DATA_WIDTH-1:0] cache_a_q, cache_b_q;
    logic                  cache_uns_q;
    logic [DATA_WIDTH-1:0] cache_quo_q, cache_rmd_q;

    logic req, req_uns, div_by_zero, overflow, cache_hit, accept, div_finish;

    assign req         = i_valid & i_funct3[2];
    assign req_uns     = i_funct3[0];
    assign div_by_zero = (i_rs2 == '0);
    assign overflow    = !req_uns && (i_rs1 == MIN_NEG) && (i_rs2 == ALL_ONES);
    assign cache_hit   = cache_valid_q && (i_rs1 == cache_a_q) && (i_rs2 == cache_b_q)
                         && (req_uns == cache_uns_q);
    assign accept      = (state_q == S_IDLE) && req && !i_flush;
    assign div_finish  = (state_q == S_BUSY) && i_div_done && !i_flush;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req && !i_flush) begin
                    state_d = (div_by_zero || overflow || cache_hit) ? S_DONE : S_START;
                end
            end
            S_START: state_d = i_flush ? S_IDLE : S_BUSY;
            S_BUSY: begin
                // A flush that coincides with completion has nothing left to drain.
                if (i_flush) begin
                    state_d = i_div_done ? S_IDLE : S_DRAIN;
                end else if (i_div_done) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (i_div_done) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall     = req && (state_q != S_DONE) && !i_flush;
        o_valid     = (state_q == S_DONE) && !i_flush;
        o_div_start = (state_q == S_START) && !i_flush;
    end

    // Operands stay put until the next acceptance; the divider reads them combinationally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
            uns_q  <= 1'b0;
            rem_q  <= 1'b0;
            rd_q   <= '0;
            quo_q  <= '0;
            rmd_q  <= '0;
        end else if (accept) begin
            op_a_q <= i_rs1;
            op_b_q <= i_rs2;
            uns_q  <= req_uns;
            rem_q  <= i_funct3[1];
            rd_q   <= i_rd;
            if (div_by_zero) begin
                quo_q <= ALL_ONES;
                rmd_q <= i_rs1;
            end else if (overflow) begin
                quo_q <= MIN_NEG;
                rmd_q <= '0;
            end else if (cache_hit) begin
                quo_q <= cache_quo_q;
                rmd_q <= cache_rmd_q;
            end
        end else if (div_finish) begin
            quo_q <= i_div_quotient;
            rmd_q <= i_div_remainder;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_uns_q   <= 1'b0;
            cache_quo_q   <= '0;
            cache_rmd_q   <= '0;
        end else if (div_finish) begin
            cache_valid_q <= 1'b1;
            cache_a_q     <= op_a_q;
            cache_b_q     <= op_b_q;
            cache_uns_q   <= uns_q;
            cache_quo_q   <= i_div_quotient;
            cache_rmd_q   <= i_div_remainder;
        end
    end

    assign o_result       = rem_q ? rmd_q : quo_q;
    assign o_rd           = rd_q;
    assign o_div_a        = op_a_q;
    assign o_div_b        = op_b_q;
    assign o_div_unsigned = uns_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: fixed-latency divider model plus a RISC-V division
// reference and a shadow of the result cache.
module tb_div_seq_ctrl;

    localparam int DIV_CYCLES = 34;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd3;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_stall, o_valid, o_div_start, o_div_unsigned;
    logic [31:0] o_result, o_div_a, o_div_b;
    logic [4:0]  o_rd;
    logic [31:0] i_div_quotient, i_div_remainder;
    logic        i_div_done;
    logic [2:0]  o_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .n_rst(n_rst), .i_valid(i_valid), .i_funct3(i_funct3),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
        .o_div_start(o_div_start), .o_div_unsigned(o_div_unsigned),
        .o_div_a(o_div_a), .o_div_b(o_div_b),
        .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
        .i_div_done(i_div_done), .o_state(o_state)
    );

    // RISC-V M-extension division semantics.
    function automatic logic [31:0] ref_calc(input logic uns, input logic rem,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (uns) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return rem ? r : q;
    endfunction

    // Divider: done rises DIV_CYCLES cycles after the start pulse and stays high until the next start.
    logic div_busy;
    int   div_cnt;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            i_div_done <= 1'b0;
            div_busy   <= 1'b0;
            div_cnt    <= 0;
        end else if (o_div_start) begin
            i_div_done <= 1'b0;
            div_busy   <= 1'b1;
            div_cnt    <= 1;
        end else if (div_busy) begin
            div_cnt <= div_cnt + 1;
            if (div_cnt + 1 == DIV_CYCLES) begin
                i_div_done <= 1'b1;
                div_busy   <= 1'b0;
            end
        end
    end
    assign i_div_quotient  = ref_calc(o_div_unsigned, 1'b0, o_div_a, o_div_b);
    assign i_div_remainder = ref_calc(o_div_unsigned, 1'b1, o_div_a, o_div_b);

    // Driver: presents one request from cycle 0 until o_valid; called and returns at posedge+1.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rd_o,
                          output int lat, output int starts, output int start_cyc,
                          output int stall_cnt, output bit got);
        i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
        got = 1'b0; res = '0; rd_o = '0; lat = -1; starts = 0; start_cyc = -1; stall_cnt = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (o_div_start) begin starts++; start_cyc = c; end
            if (o_stall) stall_cnt++;
            if (o_valid) begin got = 1'b1; res = o_result; rd_o = o_rd; lat = c; end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_funct3 = 3'b000;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_valid, o_div_start, o_stall, o_div_unsigned} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0000", {o_valid, o_div_start, o_stall, o_div_unsigned});
        end
        checks++;
        if ({o_result, o_rd} !== 37'd0) begin
            errors++; $display("FAIL reset_result got=%h/%0d exp=0/0", o_result, o_rd);
        end
        checks++;
        if ({o_div_a, o_div_b} !== 64'd0) begin
            errors++; $display("FAIL reset_operands got=%h/%h exp=0/0", o_div_a, o_div_b);
        end
        checks++;
        if (o_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state got=%0d exp=%0d", o_state, ST_IDLE);
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_not_request();
        i_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            i_funct3 = (c < 3) ? 3'b000 : 3'b011;
            i_rs1 = $urandom; i_rs2 = $urandom;
            @(negedge clk);
            checks++;
            if ({o_stall, o_valid, o_div_start} !== 3'b000 || o_state !== ST_IDLE) begin
                errors++; $display("FAIL not_request c=%0d got stall/valid/start=%b state=%0d exp=000 state=0",
                                   c, {o_stall, o_valid, o_div_start}, o_state);
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_funct3 = 3'b000;
    endtask

    task automatic test_div_signed();
        logic [31:0] res; logic [4:0] rd_o; int lat, starts, scyc, stalls; bit got;
        run_op(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd5, res, rd_o, lat, starts, scyc, stalls, got);
        checks++;
        if (!got) begin errors++; $display("FAIL div_signed_timeout got=no_valid exp=valid"); end
        checks++;
        if (res !== 32'hFFFF_FFF2 || rd_o !== 5'd5) begin
            errors++; $display("FAIL div_signed_result got=%h rd=%0d exp=fffffff2 rd=5", res, rd_o);
        end
        checks++;
        if (starts != 1 || scyc != 1) begin
            errors++; $display("FAIL div_signed_start got=%0d@%0d exp=1@1", starts, scyc);
        end
        checks++;
        if (lat != 36 || stalls != 36) begin
            errors++; $display("FAIL div_signed_timing got lat=%0d stalls=%0d exp 36/36", lat, stalls);
        end
    endtask

    task automatic test_cache_hit();
        logic [31:0] res; logic [4:0] rd_o; int lat, starts, scyc, stalls; bit got;
        run_op(3'b101, 32'hFFFF_FFFF, 32'd2, 5'd9, res, rd_o, lat, starts, scyc, stalls, got);
        checks++;
        if (!got || res !== 32'h7FFF_FFFF || lat != 36 || starts != 1) begin
            errors++; $display("FAIL divu_fill got=%h lat=%0d starts=%0d exp=7fffffff lat=36 starts=1", res, lat, starts);
        end
        run_op(3'b111, 32'hFFFF_FFFF, 32'd2, 5'd10, res, rd_o, lat, starts, scyc, stalls, got);
        checks++;
        if (!got || res !== 32'd1 || rd_o !== 5'd10) begin
            errors++; $display("FAIL remu_hit_result got=%h rd=%0d exp=1 rd=10", res, rd_o);
        end
        checks++;
        if (starts != 0 || lat != 1 || stalls != 1) begin
            errors++; $display("FAIL remu_hit_timing got starts=%0d lat=%0d stalls=%0d exp 0/1/1", starts, lat, stalls);
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3_t [6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b101};
        logic [31:0] a_t  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] b_t  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] r_t  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0};
        int          s_t  [6] = '{0, 0, 0, 0, 0, 1};
        logic [31:0] res; logic [4:0] rd_o; int lat, starts, scyc, stalls; bit got;
        for (int i = 0; i < 6; i++) begin
            run_op(f3_t[i], a_t[i], b_t[i], 5'(i + 1), res, rd_o, lat, starts, scyc, stalls, got);
            checks++;
            if (!got || res !== r_t[i] || rd_o !== 5'(i + 1)) begin
                errors++; $display("FAIL special_result[%0d] got=%h rd=%0d exp=%h rd=%0d", i, res, rd_o, r_t[i], i + 1);
            end
            checks++;
            if (starts != s_t[i] || lat != (s_t[i] != 0 ? 36 : 1) || stalls != lat) begin
                errors++; $display("FAIL special_timing[%0d] got starts=%0d lat=%0d stalls=%0d exp starts=%0d", i, starts, lat, stalls, s_t[i]);
            end
        end
    endtask

    task automatic test_flush_short();
        int bad;
        i_valid = 1'b1; i_funct3 = 3'b100; i_rs1 = 32'd50; i_rs2 = 32'd7; i_rd = 5'd3; i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_div_start !== 1'b0) begin
            errors++; $display("FAIL flush_idle_stall got stall=%b start=%b exp 0/0", o_stall, o_div_start);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (o_state !== ST_IDLE || o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle_state got=%0d valid=%b exp=0 valid=0", o_state, o_valid);
        end
        @(posedge clk); #1;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (o_div_start !== 1'b0 || o_stall !== 1'b0) begin
            errors++; $display("FAIL flush_start got start=%b stall=%b exp 0/0", o_div_start, o_stall);
        end
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_div_start || o_valid || o_state !== ST_IDLE) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL flush_start_quiet got=%0d active cycles exp=0", bad); end
        i_valid = 1'b1; i_funct3 = 3'b100; i_rs1 = 32'd50; i_rs2 = 32'd0;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_done got valid=%b exp=0", o_valid); end
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (o_state !== ST_IDLE || o_valid !== 1'b0) begin
            errors++; $display("FAIL flush_done_state got=%0d valid=%b exp=0/0", o_state, o_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_drain();
        int drain_bad, valid_cyc, stall_bad, n_starts;
        int start_c [$];
        logic [31:0] res; logic [4:0] rd_o;
        drain_bad = 0; stall_bad = 0; valid_cyc = -1; n_starts = 0; res = '0; rd_o = '0;
        i_valid = 1'b1; i_funct3 = 3'b100; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_rd = 5'd7;
        for (int c = 0; c < 120 && valid_cyc < 0; c++) begin
            if (c == 10) i_flush = 1'b1;
            if (c == 11) begin i_flush = 1'b0; i_rs1 = 32'd9; i_rs2 = 32'd3; i_rd = 5'd8; end
            @(negedge clk);
            if (c >= 11 && c <= 35 && o_state !== ST_DRAIN) drain_bad++;
            if (c == 10 && o_stall) stall_bad++;
            if (c >= 11 && !o_valid && !o_stall) stall_bad++;
            if (o_div_start) begin n_starts++; start_c.push_back(c); end
            if (o_valid) begin valid_cyc = c; res = o_result; rd_o = o_rd; end
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_funct3 = 3'b000;
        checks++;
        if (drain_bad != 0) begin errors++; $display("FAIL drain_state got=%0d off-DRAIN cycles exp=0", drain_bad); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL drain_stall got=%0d bad cycles exp=0", stall_bad); end
        checks++;
        if (n_starts != 2 || start_c[0] != 1 || start_c[n_starts-1] != 37) begin
            errors++; $display("FAIL drain_starts got n=%0d last=%0d exp n=2 at 1,37", n_starts, start_c[n_starts-1]);
        end
        checks++;
        if (valid_cyc != 72 || res !== 32'd3 || rd_o !== 5'd8) begin
            errors++; $display("FAIL drain_result got cyc=%0d res=%h rd=%0d exp cyc=72 res=3 rd=8", valid_cyc, res, rd_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp, res; logic [4:0] rd_o; int lat, starts, scyc, stalls; bit got;
        logic [2:0] f3_t [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        a = $urandom | 32'h0000_0100;
        b = 32'($urandom_range(1, 1000));
        for (int i = 0; i < 4; i++) begin
            exp = ref_calc(f3_t[i][0], f3_t[i][1], a, b);
            run_op(f3_t[i], a, b, 5'(20 + i), res, rd_o, lat, starts, scyc, stalls, got);
            checks++;
            if (!got || res !== exp || rd_o !== 5'(20 + i)) begin
                errors++; $display("FAIL b2b_result[%0d] got=%h rd=%0d exp=%h rd=%0d", i, res, rd_o, exp, 20 + i);
            end
            checks++;
            if (starts != ((i % 2 == 0) ? 1 : 0) || lat != ((i % 2 == 0) ? 36 : 1) || stalls != lat) begin
                errors++; $display("FAIL b2b_timing[%0d] got starts=%0d lat=%0d stalls=%0d", i, starts, lat, stalls);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic [4:0] rd_o; int lat, starts, scyc, stalls; bit got;
        run_op(3'b100, 32'd77, 32'd5, 5'd4, res, rd_o, lat, starts, scyc, stalls, got);
        checks++;
        if (!got || res !== 32'd15 || starts != 1) begin
            errors++; $display("FAIL rstmid_fill got=%h starts=%0d exp=f starts=1", res, starts);
        end
        i_valid = 1'b1; i_funct3 = 3'b100; i_rs1 = 32'd1234; i_rs2 = 32'd7; i_rd = 5'd6;
        repeat (20) @(posedge clk);
        #1;
        n_rst = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_valid, o_div_start, o_stall, o_div_unsigned, o_result, o_rd, o_div_a, o_div_b, o_state} !== '0) begin
            errors++; $display("FAIL rstmid_outputs got a=%h b=%h res=%h rd=%0d state=%0d exp all 0",
                               o_div_a, o_div_b, o_result, o_rd, o_state);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_op(3'b100, 32'd77, 32'd5, 5'd4, res, rd_o, lat, starts, scyc, stalls, got);
        checks++;
        if (!got || res !== 32'd15 || starts != 1 || lat != 36) begin
            errors++; $display("FAIL rstmid_cache_cleared got=%h starts=%0d lat=%0d exp=f starts=1 lat=36", res, starts, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic        m_cv, m_u;
        logic [31:0] m_a, m_b, a, b, res, exp;
        logic [2:0]  f3;
        logic [4:0]  rd, rd_o;
        int          sel, exp_starts, lat, starts, scyc, stalls;
        bit          got, special, hit;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        m_cv = 1'b0; m_u = 1'b0; m_a = '0; m_b = '0;
        for (int n = 0; n < 30; n++) begin
            f3  = 3'(4 + $urandom_range(0, 3));
            rd  = 5'($urandom_range(1, 31));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = (sel > 7) ? 32'($urandom_range(1, 20)) : $urandom;
            if (sel <= 1) b = 32'd0;
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel <= 5 && m_cv) begin a = m_a; b = m_b; end
            special    = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            hit        = !special && m_cv && a == m_a && b == m_b && f3[0] == m_u;
            exp_starts = (special || hit) ? 0 : 1;
            exp_q.push_back(ref_calc(f3[0], f3[1], a, b));
            run_op(f3, a, b, rd, res, rd_o, lat, starts, scyc, stalls, got);
            exp = exp_q.pop_front();
            if (exp_starts == 1) begin m_cv = 1'b1; m_a = a; m_b = b; m_u = f3[0]; end
            checks++;
            if (!got) begin errors++; $display("FAIL rand_timeout[%0d] got=no_valid exp=valid", n); end
            checks++;
            if (res !== exp || rd_o !== rd) begin
                errors++; $display("FAIL rand_result[%0d] f3=%b a=%h b=%h got=%h rd=%0d exp=%h rd=%0d", n, f3, a, b, res, rd_o, exp, rd);
            end
            checks++;
            if (starts != exp_starts) begin
                errors++; $display("FAIL rand_starts[%0d] got=%0d exp=%0d", n, starts, exp_starts);
            end
            checks++;
            if (lat != (exp_starts != 0 ? 36 : 1) || stalls != lat) begin
                errors++; $display("FAIL rand_timing[%0d] got lat=%0d stalls=%0d exp lat=%0d", n, lat, stalls, exp_starts != 0 ? 36 : 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_not_request();
        test_div_signed();
        test_cache_hit();
        test_special();
        test_flush_short();
        test_flush_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer between the EX stage of the 5-stage RV32IM pipeline and the 32-bit multi-cycle divider. It decodes DIV/DIVU/REM/REMU requests, stalls the pipeline while the divider runs, and resolves the RISC-V special cases (divide-by-zero, signed overflow) without using the divider. It also keeps a one-entry quotient/remainder cache, so a DIV followed by a REM on the same operands (or the reverse) completes in one cycle.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- i_valid  in  1  EX holds an M-extension op; held stable while o_stall=1
- i_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is not a request
- i_rs1, i_rs2  in  DATA_WIDTH  dividend, divisor
- i_rd  in  5  destination register
- i_flush  in  1  kill the in-flight op
- o_stall  out  1  freeze the pipeline (combinational)
- o_valid  out  1  one-cycle result strobe
- o_result  out  DATA_WIDTH  quotient or remainder
- o_rd  out  5  destination of o_result
- o_div_start  out  1  divider start pulse
- o_div_unsigned  out  1  divider unsigned select
- o_div_a, o_div_b  out  DATA_WIDTH  divider operands; registered and held
- i_div_quotient, i_div_remainder  in  DATA_WIDTH  divider results, sign-corrected
- i_div_done  in  1  divider completion level

## Operation
- req = i_valid & i_funct3[2]. uns = funct3[0]. want_rem = funct3[1].
- States: IDLE, START, BUSY, DRAIN, DONE.
- IDLE, on req & !i_flush:
  - Latch rs1, rs2, uns, want_rem and rd into operand registers that drive o_div_a, o_div_b and o_div_unsigned.
  - rs2==0: quotient=all-ones, remainder=rs1. Go to DONE.
  - Otherwise, if !uns & rs1==0x80000000 & rs2==0xFFFFFFFF: quotient=0x80000000, remainder=0. Go to DONE.
  - Otherwise, on a cache hit (cache_valid & rs1, rs2, uns equal to the cached values): take the cached quotient/remainder. Go to DONE.
  - Otherwise go to START.
- START: o_div_start=1 for exactly this cycle, then BUSY. On i_flush: no pulse, go to IDLE.
- BUSY: wait for i_div_done=1. Then capture quotient and remainder into the result register and the cache, set cache_valid, go to DONE. On i_flush: go to DRAIN.
- DRAIN: wait for i_div_done=1, discard the result, go to IDLE. The cache is unchanged.
- DONE: o_valid=1 unless i_flush. o_result = want_rem ? remainder : quotient. Go to IDLE.
- o_stall = req & (state != DONE) & !i_flush. This covers IDLE on the acceptance cycle and DRAIN with a new req waiting.
- Operand registers stay stable from IDLE acceptance through DONE/DRAIN exit. This is required because the divider's sign correction reads its operand inputs combinationally.
- The controller never samples i_div_done in the cycle it asserts o_div_start, so there is no combinational loop.
- Special cases never assert o_div_start and never update the cache.
- Reset values:
  - state=IDLE.
  - o_valid=0, o_div_start=0.
  - o_result, o_rd, o_div_a, o_div_b, o_div_unsigned = 0.
  - cache_valid=0.

## Timing
- Cycle 0 is the first cycle req is seen in IDLE.
- Divider path:
  - START in cycle 1, o_div_start high in cycle 1.
  - Divider done in cycle 35, DONE/o_valid in cycle 36.
  - o_stall high in cycles 0-35, low in cycle 36.
- Special-case or cache hit: o_stall high in cycle 0, o_valid in cycle 1.
- Back-to-back: in the DONE cycle the pipeline advances. The next req is accepted in the following IDLE cycle.
- Flush:
  - In IDLE, START or DONE: return to IDLE next cycle, with no o_valid and no start.
  - In BUSY: DRAIN until the divider finishes its fixed run. A new req during DRAIN stays stalled and is accepted in the IDLE cycle after DRAIN.
- Reset mid-operation: immediate return to reset values. The divider is reset by the same n_rst.

## Test plan
- DIV rs1=100, rs2=0xFFFFFFF9 (-7) -> o_div_start pulse in cycle 1, o_valid in cycle 36, o_result=0xFFFFFFF2 (-14); o_stall high in cycles 0-35.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF at cycle 36. Then REMU with the same operands -> cache hit, no start, o_result=1 one cycle after acceptance.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with o_valid in cycle 1 and no o_div_start. Signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIV 1000/3 with i_flush in cycle 10 -> no o_valid; state DRAIN until divider done. A DIV 9/3 held during DRAIN gets its start pulse in the cycle after the drained op's i_div_done, then result 3.
- n_rst low in cycle 20 of a divide -> all outputs 0 during reset. After release, re-issuing the previously cached operands produces an o_div_start pulse (cache invalidated).
- funct3=000 with i_valid=1 -> o_stall=0, o_valid=0, no start.
